product_code_encoder: RTL and testbench

//  Streaming 2-D single-parity-check product-code encoder; the parametrised successor of the fixed 16->32 block encoder.

---
 rtl/product_code_encoder.sv | 134 +++++++++++++
 tb/tb_product_code_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_code_encoder.sv
// product_code_encoder
// Streaming 2-D single-parity-check product-code encoder. Accepts a ROWS x COLS
// data block one row per transfer, emits each row extended with its even
// row-parity bit, then closes the block with one column-parity row whose bit 0
// is the check-on-checks corner bit. Valid/ready on both sides, single-register
// output stage, full throughput of one beat per cycle.
module product_code_encoder #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [COLS-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [COLS:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int unsigned ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int unsigned OUT_W = COLS + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_e;

    state_e            state_q;
    logic [ROW_W-1:0]  row_cnt_q;
    logic [ROW_W-1:0]  row_cnt_d;
    logic [COLS-1:0]   col_acc_q;
    logic [COLS-1:0]   col_acc_d;
    logic [OUT_W-1:0]  out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic [CNT_W-1:0]  blk_cnt_d;
    logic [OUT_W-1:0]  data_row_d;
    logic [OUT_W-1:0]  par_row_d;

    logic              slot_free_c;
    logic              in_fire_c;
    logic              out_fire_c;
    logic              par_load_c;
    logic              last_row_c;

    // Handshake qualifiers; in_ready is held low in reset and in the flush cycle.
    always_comb begin
        slot_free_c = !out_valid_q || out_ready;
        in_ready    = rst_n && !flush && (state_q == ST_DATA) && slot_free_c;
        in_fire_c   = in_valid && in_ready;
        out_fire_c  = out_valid_q && out_ready;
        par_load_c  = (state_q == ST_PARITY) && slot_free_c;
        last_row_c  = (row_cnt_q == LAST_ROW);
    end

    // Next-value datapath: row counter, column accumulator, encoded beats.
    always_comb begin
        row_cnt_d  = row_cnt_q + ROW_W'(1);
        col_acc_d  = col_acc_q ^ in_data;
        data_row_d = {in_data, ^in_data};
        par_row_d  = {col_acc_q, ^col_acc_q};
        blk_cnt_d  = blk_cnt_q + CNT_W'(1);
    end

    // Block sequencer and output register; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            row_cnt_q   <= '0;
            col_acc_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            blk_cnt_q   <= '0;
        end else if (flush) begin
            // Abort the block in flight; the completed-block count survives.
            state_q     <= ST_DATA;
            row_cnt_q   <= '0;
            col_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (in_fire_c) begin
                        out_data_q  <= data_row_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        col_acc_q   <= col_acc_d;
                        if (last_row_c) begin
                            state_q <= ST_PARITY;
                        end else begin
                            row_cnt_q <= row_cnt_d;
                        end
                    end else if (out_fire_c) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    // A stalled output cannot transfer here, so only the load case matters.
                    if (par_load_c) begin
                        out_data_q  <= par_row_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        col_acc_q   <= '0;
                        row_cnt_q   <= '0;
                        blk_cnt_q   <= blk_cnt_d;
                        state_q     <= ST_DATA;
                    end
                end
                default: begin
                    state_q <= ST_DATA;
                end
            endcase
        end
    end

    // Registered outputs.
    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        blk_cnt   = blk_cnt_q;
    end

endmodule

// File: tb/tb_product_code_encoder.sv
// tb_product_code_encoder
// Directed bench for the product-code encoder with a scoreboard queue. Two
// instances share stimulus: one with the default 16-bit block counter and one
// with a 2-bit counter to exercise wrap-around.
module tb_product_code_encoder;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned W    = COLS + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            flush;
    logic [COLS-1:0] in_data;
    logic            in_valid;
    logic            out_ready;
    logic            in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [15:0]     blk_cnt;
    logic            d2_in_ready;
    logic [W-1:0]    d2_out_data;
    logic            d2_out_valid;
    logic            d2_out_last;
    logic [1:0]      d2_blk_cnt;

    product_code_encoder #(.ROWS(ROWS), .COLS(COLS), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .blk_cnt(blk_cnt)
    );

    product_code_encoder #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(d2_in_ready),
        .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_last(d2_out_last), .blk_cnt(d2_blk_cnt)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] rx_q[$];
    int           mdl_row;
    logic [COLS-1:0] mdl_col;
    bit           par_pend;
    int           mdl_blk;
    logic [W-1:0] col_rx;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    bit           fire_in;
    bit           fire_out;
    logic         last_in_ready;
    logic [W-1:0] last_par;
    int           beat_no;
    int           stall_beat;
    int           stall_len;
    int           stall_rem;
    bit           hold_low;
    bit           rand_ready;
    int           fires;
    logic [W-1:0] exp_t1[5] = '{5'b10100, 5'b01111, 5'b00000, 5'b11110, 5'b00101};
    int           exp_w[5]  = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mdl_row  = 0;
        mdl_col  = '0;
        par_pend = 1'b0;
        col_rx   = '0;
    endtask

    // One clock: sample/check at negedge, update the model, then drive out_ready after posedge.
    task automatic step();
        logic       exp_rdy;
        logic [W:0] e;
        @(negedge clk);
        exp_rdy = rst_n && !flush && !par_pend && (!out_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("d2_in_ready", 32'(d2_in_ready), 32'(exp_rdy));
        last_in_ready = in_ready;
        fire_in  = rst_n && in_valid && in_ready;
        fire_out = rst_n && out_valid && out_ready;
        if (rst_n) begin
            chk("blk_cnt", 32'(blk_cnt), mdl_blk & 32'hFFFF);
            chk("blk_cnt_w2", 32'(d2_blk_cnt), mdl_blk & 32'h3);
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (exp_q.size() == 0) chk("idle_valid", 32'(out_valid), 32'd0);
            if (fire_out && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[W-1:0]));
                chk("out_last", 32'(out_last), 32'(e[W]));
                chk("d2_out_data", 32'(d2_out_data), 32'(e[W-1:0]));
                chk("d2_out_last", 32'(d2_out_last), 32'(e[W]));
                chk("d2_out_valid", 32'(d2_out_valid), 32'd1);
                chk("row_parity", 32'(^out_data), 32'd0);
                col_rx = col_rx ^ out_data;
                rx_q.push_back(out_data);
                beat_no++;
                if (out_last) begin
                    chk("col_parity", 32'(col_rx), 32'd0);
                    col_rx   = '0;
                    last_par = out_data;
                end
                if (beat_no == stall_beat) stall_rem = stall_len;
            end
        end
        prev_stall = rst_n && !flush && out_valid && !out_ready;
        prev_data  = out_data;
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            if (par_pend && (!out_valid || out_ready)) begin
                par_pend = 1'b0;
                mdl_blk++;
            end
            if (fire_in) begin
                exp_q.push_back({1'b0, in_data, ^in_data});
                mdl_col = mdl_col ^ in_data;
                mdl_row++;
                if (mdl_row == ROWS) begin
                    exp_q.push_back({1'b1, mdl_col, ^mdl_col});
                    mdl_col  = '0;
                    mdl_row  = 0;
                    par_pend = 1'b1;
                end
            end
        end
        if (!rst_n) mdl_blk = 0;
        @(posedge clk);
        #1;
        if (stall_rem > 0) begin
            out_ready = 1'b0;
            stall_rem--;
        end else if (hold_low) begin
            out_ready = 1'b0;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send_row(input logic [COLS-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            step();
            if (fire_in) break;
        end
        chk("send_timeout", 32'(fire_in), 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            in_data = COLS'($urandom);
            step();
            if (exp_q.size() == 0) break;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic send_t1();
        send_row(4'b1010);
        send_row(4'b0111);
        send_row(4'b0000);
        send_row(4'b1111);
        drain();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        stall_beat = -1; stall_len = 0; stall_rem = 0; beat_no = 0;
        hold_low = 1'b0; rand_ready = 1'b0; mdl_blk = 0; prev_stall = 1'b0;
        last_par = '0; prev_data = '0;
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("rst_blk_cnt_w2", 32'(d2_blk_cnt), 32'd0);

        // T1: reference block, output always ready
        rx_q.delete();
        send_t1();
        chk("t1_beats", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t1_seq", 32'(rx_q[i]), 32'(exp_t1[i]));
        chk("t1_blk", 32'(blk_cnt), 32'd1);

        // T2: same block, output stalled three cycles after beat 2
        rx_q.delete();
        beat_no = 0; stall_beat = 2; stall_len = 3;
        send_t1();
        stall_beat = -1;
        chk("t2_beats", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_seq", 32'(rx_q[i]), 32'(exp_t1[i]));
        chk("t2_blk", 32'(blk_cnt), 32'd2);

        // T3: three back-to-back blocks at full rate
        fires = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            in_data = COLS'($urandom);
            step();
            chk("t3_in_ready", 32'(last_in_ready), 32'((c % 5) != 0));
            if (fire_out) fires++;
        end
        in_valid = 1'b0;
        step();
        if (fire_out) fires++;
        chk("t3_beats", 32'(fires), 32'd15);
        drain();
        chk("t3_blk", 32'(blk_cnt), 32'd5);

        // T4: flush after two rows, then a clean block
        send_row(4'b1100);
        send_row(4'b0011);
        flush = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_flush_valid", 32'(out_valid), 32'd0);
        last_par = '0;
        send_t1();
        chk("t4_parity", 32'(last_par), 32'b00101);
        chk("t4_blk", 32'(blk_cnt), 32'd6);

        // T5: reset mid-block while the output is stalled
        hold_low = 1'b1;
        out_ready = 1'b0;
        send_row(4'b1010);
        in_valid = 1'b1; in_data = 4'b0111;
        step();
        step();
        chk("t5_stalled", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; hold_low = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        chk("t5_out_data", 32'(out_data), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_last", 32'(out_last), 32'd0);
        chk("t5_blk", 32'(blk_cnt), 32'd0);
        chk("t5_blk_w2", 32'(d2_blk_cnt), 32'd0);
        last_par = '0;
        send_t1();
        chk("t5_parity", 32'(last_par), 32'b00101);

        // T6: five random blocks with random backpressure; 2-bit counter wraps
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rand_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int r = 0; r < ROWS; r++) send_row(COLS'($urandom));
            drain();
            chk("t6_blk_w2", 32'(d2_blk_cnt), 32'(exp_w[b]));
        end
        rand_ready = 1'b0;
        chk("t6_blk", 32'(blk_cnt), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
